// File: rtl/regfile_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// regfile_ctrl_pkg
// Shared types and defaults for the register-file write-port controller:
//   - state_t      : controller phase (zero-fill, then arbitration)
//   - grant_idx_t  : index of a writeback requester (0 or 1)
//   - ADDR_W_DEF / DATA_W_DEF : default address / data widths
// -----------------------------------------------------------------------------
package regfile_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef logic grant_idx_t;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter. Grant is combinational from the valids and
// the last granted index; the last-grant register advances only on a transfer.
// Ports:
//   i_clk, i_rst    clock, asynchronous active-high reset
//   i_valid[1:0]    request vector
//   i_xfer          a grant was consumed this cycle
//   o_grant[1:0]    one-hot grant (zero when no request)
//   o_grant_idx     index of the granted requester
// -----------------------------------------------------------------------------
module rr_arb2
    import regfile_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_valid,
    input  logic       i_xfer,
    output logic [1:0] o_grant,
    output grant_idx_t o_grant_idx
);

    grant_idx_t r_last;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = 1'b0;
        if (i_valid == 2'b11) begin
            // Tie goes to the requester that was not served last.
            o_grant_idx = ~r_last;
        end else if (i_valid[1]) begin
            o_grant_idx = 1'b1;
        end
        if (i_valid != 2'b00) begin
            o_grant[o_grant_idx] = 1'b1;
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last <= 1'b1;
        end else if (i_xfer) begin
            r_last <= o_grant_idx;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
// Write-port controller for the register file. After reset it zero-fills
// registers 1..NREGS-1 (one per cycle), then shares the write port between two
// valid/ready writeback requesters with round-robin arbitration.
// Ports:
//   Clk, Reset                 clock, asynchronous active-high reset
//   reqN_valid/addr/data       requester N write request
//   reqN_ready                 requester N accepted this cycle (combinational)
//   W_Addr, W_Data, Write_Reg  registered register-file write port
//   init_done                  zero-fill complete, requests accepted
//   drop_cnt                   saturating count of accepted writes to reg 0
// -----------------------------------------------------------------------------
module regfile_wr_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned NREGS   = 32,
    parameter int unsigned INIT_EN = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data,
    output logic              Write_Reg,
    output logic              init_done,
    output logic [7:0]        drop_cnt
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_fill_cnt;
    logic              w_fill_last;
    logic              w_run;
    logic              w_xfer;
    logic [1:0]        w_grant;
    grant_idx_t        w_grant_idx;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_sel_zero;

    assign w_fill_last = (r_fill_cnt == ADDR_W'(NREGS - 1));
    assign w_run       = (r_state == ST_RUN);

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && w_fill_last) begin
            w_state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    rr_arb2 u_arb (
        .i_clk       (Clk),
        .i_rst       (Reset),
        .i_valid     ({req1_valid, req0_valid}),
        .i_xfer      (w_xfer),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // Any valid in RUN is granted, so a transfer happens whenever one is valid.
    assign w_xfer     = w_run & (req0_valid | req1_valid);
    assign req0_ready = w_run & w_grant[0];
    assign req1_ready = w_run & w_grant[1];

    assign w_sel_addr = w_grant_idx ? req1_addr : req0_addr;
    assign w_sel_data = w_grant_idx ? req1_data : req0_data;
    assign w_sel_zero = (w_sel_addr == '0);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            W_Addr     <= '0;
            W_Data     <= '0;
            Write_Reg  <= 1'b0;
            init_done  <= 1'b0;
            drop_cnt   <= '0;
            r_fill_cnt <= ADDR_W'(1);
        end else if (r_state == ST_INIT) begin
            W_Addr     <= r_fill_cnt;
            W_Data     <= '0;
            Write_Reg  <= 1'b1;
            r_fill_cnt <= r_fill_cnt + ADDR_W'(1);
            if (w_fill_last) begin
                init_done <= 1'b1;
            end
        end else begin
            init_done <= 1'b1;
            if (w_xfer && !w_sel_zero) begin
                W_Addr    <= w_sel_addr;
                W_Data    <= w_sel_data;
                Write_Reg <= 1'b1;
            end else begin
                Write_Reg <= 1'b0;
            end
            // Writes to register 0 are accepted but discarded, only counted.
            if (w_xfer && w_sel_zero && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_arbiter
// Random valid/ready traffic from two requesters against a cycle-level
// reference model of the zero-fill sequence and round-robin write arbitration.
// -----------------------------------------------------------------------------
module tb_regfile_wr_arbiter;

    localparam int NREGS = 32;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        v [2];
    logic [4:0]  a [2];
    logic [31:0] d [2];
    logic        req0_ready, req1_ready;
    logic [4:0]  W_Addr;
    logic [31:0] W_Data;
    logic        Write_Reg;
    logic        init_done;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          m_filled;
    int          m_last;
    bit          m_wr;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          m_done;
    int          m_drop;
    bit          acc [2];

    always #5 Clk = ~Clk;

    regfile_wr_arbiter #(
        .ADDR_W  (5),
        .DATA_W  (32),
        .NREGS   (NREGS),
        .INIT_EN (1)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .req0_valid (v[0]),
        .req0_addr  (a[0]),
        .req0_data  (d[0]),
        .req0_ready (req0_ready),
        .req1_valid (v[1]),
        .req1_addr  (a[1]),
        .req1_data  (d[1]),
        .req1_ready (req1_ready),
        .W_Addr     (W_Addr),
        .W_Data     (W_Data),
        .Write_Reg  (Write_Reg),
        .init_done  (init_done),
        .drop_cnt   (drop_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_val("Write_Reg", 32'(Write_Reg), 32'(m_wr));
        check_val("W_Addr",    32'(W_Addr),    32'(m_addr));
        check_val("W_Data",    W_Data,         m_data);
        check_val("init_done", 32'(init_done), 32'(m_done));
        check_val("drop_cnt",  32'(drop_cnt),  32'(m_drop));
    endtask

    task automatic model_reset();
        m_filled = 0;
        m_last   = 1;
        m_wr     = 1'b0;
        m_addr   = '0;
        m_data   = '0;
        m_done   = 1'b0;
        m_drop   = 0;
        acc[0]   = 1'b0;
        acc[1]   = 1'b0;
    endtask

    // Asserts Reset away from a clock edge, checks the asynchronous clear,
    // then releases it on a falling edge.
    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        v[0] = 1'b0;
        v[1] = 1'b0;
        model_reset();
        #1;
        check_outputs();
        check_val("req0_ready_rst", 32'(req0_ready), 32'd0);
        check_val("req1_ready_rst", 32'(req1_ready), 32'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        #1;
        check_outputs();
    endtask

    // One clock cycle: new stimulus, ready check, model step, output check.
    task automatic one_cycle(input int p_valid, input bit zero_mode);
        int w;
        for (int i = 0; i < 2; i++) begin
            // A pending request holds addr/data until it is accepted.
            if (!v[i] || acc[i]) begin
                v[i] = ($urandom_range(99) < p_valid);
                if (zero_mode || $urandom_range(7) == 0)
                    a[i] = '0;
                else
                    a[i] = 5'($urandom_range(31));
                d[i] = $urandom;
            end
        end
        #1;
        w = -1;
        if (m_filled >= NREGS - 1) begin
            if (v[0] && v[1]) w = 1 - m_last;
            else if (v[0])    w = 0;
            else if (v[1])    w = 1;
        end
        check_val("req0_ready", 32'(req0_ready), 32'(w == 0));
        check_val("req1_ready", 32'(req1_ready), 32'(w == 1));
        acc[0] = (w == 0);
        acc[1] = (w == 1);

        if (m_filled < NREGS - 1) begin
            m_filled++;
            m_wr   = 1'b1;
            m_addr = 5'(m_filled);
            m_data = '0;
            if (m_filled == NREGS - 1) m_done = 1'b1;
        end else begin
            m_done = 1'b1;
            m_wr   = 1'b0;
            if (w >= 0) begin
                m_last = w;
                if (a[w] != 0) begin
                    m_wr   = 1'b1;
                    m_addr = a[w];
                    m_data = d[w];
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
        end
        @(negedge Clk);
        check_outputs();
    endtask

    initial begin
        v[0] = 1'b0; v[1] = 1'b0;
        a[0] = '0;   a[1] = '0;
        d[0] = '0;   d[1] = '0;
        model_reset();

        do_reset();
        repeat (10) one_cycle(60, 1'b0);   // fill has issued address 10
        do_reset();                        // fill restarts from address 1
        repeat (31) one_cycle(60, 1'b0);
        repeat (400) one_cycle(90, 1'b0);
        repeat (200) one_cycle(40, 1'b0);
        repeat (20) one_cycle(100, 1'b0);  // strict alternation
        repeat (300) one_cycle(100, 1'b1); // drive drop_cnt into saturation
        repeat (50) one_cycle(70, 1'b0);
        do_reset();
        repeat (40) one_cycle(100, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
